instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the MIPS-31 CPU, directly upstream of the instruction decoder. Holds the architectural PC, issues word reads to instruction memory over a req/ready handshake, and presents one instruction word with its PC to the decoder under a valid/accept handshake. Computes the next PC from redirect information returned by the decode/execute side when the current instruction is accepted: sequential, BEQ/BNE, J/JAL, or JR. No branch delay slot.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_ready
- imem_addr  out  32  word address being fetched; bits [1:0] always 0
- imem_ready  in  1  response strobe; meaningful only while imem_req=1
- imem_rdata  in  32  instruction word; valid when imem_ready=1
- instr_out  out  32  held instruction word to decoder
- instr_pc  out  32  PC of instr_out
- instr_valid  out  1  instr_out/instr_pc valid
- instr_accept  in  1  consumer takes instruction; redirect inputs sampled same cycle
- br_taken  in  1  conditional branch resolved taken
- br_imm  in  16  branch immediate (instr[15:0])
- jmp  in  1  J or JAL
- jmp_index  in  26  jump index (instr[25:0])
- jr  in  1  JR
- jr_target  in  32  register value for JR
- instr_count  out  32  number of accepted instructions

## Operation
- States: RST_WAIT, FETCH, HOLD.
- RST_WAIT: imem_req=0, instr_valid=0; unconditionally -> FETCH next cycle. Guarantees any pre-reset memory transaction is abandoned.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instr_out<=imem_rdata, instr_pc<=pc, -> HOLD. Otherwise stay; imem_addr stable.
- HOLD: instr_valid=1, imem_req=0. instr_accept=0: stay, all outputs stable. instr_accept=1: pc<=next_pc, instr_count<=instr_count+1, -> FETCH.
- next_pc, with pc4 = instr_pc+4, priority jr > jmp > br_taken > sequential:
  - jr: {jr_target[31:2], 2'b00} (low bits silently dropped)
  - jmp: {pc4[31:28], jmp_index, 2'b00}
  - br_taken: pc4 + ({{14{br_imm[15]}}, br_imm, 2'b00}), 32-bit modulo
  - else pc4, 32-bit modulo (0xFFFF_FFFC wraps to 0x0000_0000)
- Redirect inputs ignored whenever instr_accept=0 or state!=HOLD.
- instr_count wraps 0xFFFF_FFFF -> 0.

## Timing
- Reset values: state=RST_WAIT, pc=RESET_PC, instr_out=0, instr_pc=RESET_PC, instr_valid=0, imem_req=0, instr_count=0.
- rst dominates every state, including FETCH with imem_ready=1 in the same cycle: response discarded, no HOLD entry.
- Memory contract: imem_ready may be asserted in the first FETCH cycle (zero-wait); response corresponds to imem_addr of that cycle.
- Zero-wait memory, always-accepting consumer: one instruction per 2 cycles (FETCH, HOLD).
- First imem_req=1 is the 2nd cycle after rst deasserts (RST_WAIT occupies the 1st).
- instr_valid rises the cycle after imem_ready; falls the cycle after instr_accept.
- Each memory wait cycle adds exactly one cycle; each consumer stall cycle adds exactly one cycle.
- All outputs registered or decoded from state only; no combinational path from any input to any output.

## Test plan
- Reset, zero-wait memory, accept always 1, no redirects -> imem_addr 0x00400000, 0x00400004, 0x00400008 on req cycles 2 apart; instr_count=3 after third accept.
- imem_ready delayed 3 cycles at 0x00400000 -> imem_req/addr held 4 cycles; instr_out equals rdata presented with ready; instr_valid next cycle.
- HOLD with accept=0 for 5 cycles -> instr_out/instr_pc/instr_valid stable, imem_req=0, instr_count unchanged.
- instr_pc=0x00400010, br_taken=1, br_imm=16'hFFFB -> next imem_addr 0x00400000; br_imm=16'h0002 -> 0x0040001C.
- instr_pc=0x00400020, jmp=1, jmp_index=26'h0100010 -> 0x00400040; same cycle jr=1, jr_target=0x00400107 -> 0x00400104 (jr wins, low bits dropped).
- rst asserted in FETCH while imem_ready=1 -> no HOLD, instr_valid=0, one RST_WAIT cycle, refetch at 0x00400000, instr_count=0; PC wrap test: instr_pc=0xFFFFFFFC sequential -> 0x00000000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the architectural PC, fetches one word at a time
// from instruction memory and hands it to the decoder, then redirects on accept.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] br_offset;
  logic [31:0] next_pc;
  logic        capture;
  logic        retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    unique case (state)
      RST_WAIT: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_accept) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = RST_WAIT;
      end
    endcase
  end

  // Redirect priority: JR over J/JAL over taken branch over fall-through.
  always_comb begin
    pc4       = instr_pc + 32'd4;
    br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};
    next_pc   = pc4;
    if (jr) begin
      next_pc = jr_target & 32'hFFFF_FFFC;
    end else if (jmp) begin
      next_pc = {pc4[31:28], jmp_index, 2'b00};
    end else if (br_taken) begin
      next_pc = pc4 + br_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_out   <= 32'd0;
      instr_pc    <= RESET_PC;
      instr_count <= 32'd0;
    end else begin
      if (capture) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc;
      end
      if (retire) begin
        pc          <= next_pc;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // Handshake outputs come from state alone so no input reaches an output combinationally.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc & 32'hFFFF_FFFC;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against a PC/count reference model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_accept = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_imm = 16'd0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_index = 26'd0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] instr_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  logic [31:0] model_pc;
  logic [31:0] model_count;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_accept(instr_accept),
    .br_taken(br_taken), .br_imm(br_imm),
    .jmp(jmp), .jmp_index(jmp_index),
    .jr(jr), .jr_target(jr_target),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference next-PC from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] ipc, input bit b,
                                           input logic [15:0] imm, input bit j,
                                           input logic [25:0] idx, input bit r,
                                           input logic [31:0] tgt);
    logic [31:0] seq;
    int          off;
    seq = ipc + 32'd4;
    if (r) return tgt & 32'hFFFF_FFFC;
    if (j) return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
    if (b) begin
      off = $signed(imm);
      off = off * 4;
      return seq + off;
    end
    return seq;
  endfunction

  task automatic clear_redirect();
    instr_accept = 1'b0;
    br_taken = 1'b0; br_imm = 16'd0;
    jmp = 1'b0; jmp_index = 26'd0;
    jr = 1'b0; jr_target = 32'd0;
  endtask

  task automatic junk_redirect();
    br_taken = 1'($urandom); br_imm = 16'($urandom);
    jmp = 1'($urandom); jmp_index = 26'($urandom);
    jr = 1'($urandom); jr_target = $urandom;
  endtask

  task automatic do_reset();
    clear_redirect();
    imem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_pc = RESET_PC;
    model_count = 0;
    @(negedge clk);
  endtask

  // Waits (bounded) for a request, then answers it with zero wait; returns in HOLD.
  task automatic serve_fetch(input logic [31:0] word, output bit seen,
                             output logic [31:0] addr, output int unsigned req_cyc);
    int i;
    seen = 1'b0;
    i = 0;
    while (i < 8 && imem_req !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    seen = (imem_req === 1'b1);
    addr = imem_addr;
    req_cyc = cyc;
    if (seen) begin
      imem_ready = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_accept(input bit b, input logic [15:0] imm, input bit j,
                           input logic [25:0] idx, input bit r, input logic [31:0] tgt);
    br_taken = b; br_imm = imm; jmp = j; jmp_index = idx; jr = r; jr_target = tgt;
    instr_accept = 1'b1;
    @(negedge clk);
    model_pc = ref_next(model_pc, b, imm, j, idx, r, tgt);
    model_count = model_count + 1;
    clear_redirect();
  endtask

  task automatic test_reset();
    clear_redirect();
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instr_count !== 32'd0) begin n_errors++; $display("[TB] FAIL rst_count: got %h expected 0", instr_count); end
    n_checks++; if (instr_pc !== RESET_PC) begin n_errors++; $display("[TB] FAIL rst_instr_pc: got %h expected %h", instr_pc, RESET_PC); end
    n_checks++; if (instr_out !== 32'd0) begin n_errors++; $display("[TB] FAIL rst_instr_out: got %h expected 0", instr_out); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("[TB] FAIL rst_addr: got %h expected %h", imem_addr, RESET_PC); end
    rst = 1'b0;
    imem_ready = 1'b0;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_wait_req: got %b expected 0", imem_req); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, RESET_PC); end
    model_pc = RESET_PC;
    model_count = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] w, a;
    bit seen;
    int unsigned rc, prev_rc;
    prev_rc = 0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      serve_fetch(w, seen, a, rc);
      n_checks++; if (seen !== 1'b1) begin n_errors++; $display("[TB] FAIL seq_req_seen: got %b expected 1", seen); end
      n_checks++; if (a !== RESET_PC + 32'(4 * i)) begin n_errors++; $display("[TB] FAIL seq_addr: got %h expected %h", a, RESET_PC + 32'(4 * i)); end
      if (i > 0) begin
        n_checks++; if (rc - prev_rc !== 2) begin n_errors++; $display("[TB] FAIL seq_spacing: got %0d expected 2", rc - prev_rc); end
      end
      prev_rc = rc;
      n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL seq_valid: got %b expected 1", instr_valid); end
      n_checks++; if (instr_out !== w) begin n_errors++; $display("[TB] FAIL seq_instr: got %h expected %h", instr_out, w); end
      n_checks++; if (instr_pc !== model_pc) begin n_errors++; $display("[TB] FAIL seq_pc: got %h expected %h", instr_pc, model_pc); end
      do_accept(0, 0, 0, 0, 0, 0);
      n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL seq_valid_fall: got %b expected 0", instr_valid); end
    end
    n_checks++; if (instr_count !== 32'd3) begin n_errors++; $display("[TB] FAIL seq_count: got %0d expected 3", instr_count); end
  endtask

  task automatic test_mem_wait();
    logic [31:0] w, a;
    bit seen;
    int unsigned rc;
    int waits;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      waits = (t == 0) ? 3 : int'($urandom_range(0, 4));
      for (int k = 0; k < waits; k++) begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("[TB] FAIL wait_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== model_pc) begin n_errors++; $display("[TB] FAIL wait_addr: got %h expected %h", imem_addr, model_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL wait_valid: got %b expected 0", instr_valid); end
        @(negedge clk);
      end
      w = $urandom;
      serve_fetch(w, seen, a, rc);
      n_checks++; if (a !== model_pc) begin n_errors++; $display("[TB] FAIL wait_resp_addr: got %h expected %h", a, model_pc); end
      n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL wait_valid_rise: got %b expected 1", instr_valid); end
      n_checks++; if (instr_out !== w) begin n_errors++; $display("[TB] FAIL wait_instr: got %h expected %h", instr_out, w); end
      do_accept(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w, a, held_pc;
    bit seen;
    int unsigned rc;
    w = $urandom;
    serve_fetch(w, seen, a, rc);
    held_pc = model_pc;
    for (int k = 0; k < 5; k++) begin
      instr_accept = 1'b0;
      junk_redirect();
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL stall_valid: got %b expected 1", instr_valid); end
      n_checks++; if (instr_out !== w) begin n_errors++; $display("[TB] FAIL stall_instr: got %h expected %h", instr_out, w); end
      n_checks++; if (instr_pc !== held_pc) begin n_errors++; $display("[TB] FAIL stall_pc: got %h expected %h", instr_pc, held_pc); end
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req); end
      n_checks++; if (instr_count !== model_count) begin n_errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", instr_count, model_count); end
    end
    do_accept(0, 0, 0, 0, 0, 0);
    n_checks++; if (imem_addr !== held_pc + 32'd4) begin n_errors++; $display("[TB] FAIL stall_next_addr: got %h expected %h", imem_addr, held_pc + 32'd4); end
  endtask

  // Uses JR to steer to the wanted PC, fetches there and returns in HOLD.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] a;
    bit seen;
    int unsigned rc;
    serve_fetch($urandom, seen, a, rc);
    do_accept(0, 0, 0, 0, 1, target);
    serve_fetch($urandom, seen, a, rc);
    n_checks++; if (instr_pc !== target) begin n_errors++; $display("[TB] FAIL goto_pc: got %h expected %h", instr_pc, target); end
  endtask

  task automatic test_branch();
    goto_pc(32'h0040_0010);
    do_accept(1, 16'hFFFB, 0, 0, 0, 0);
    n_checks++; if (imem_addr !== 32'h0040_0000) begin n_errors++; $display("[TB] FAIL br_back: got %h expected 00400000", imem_addr); end
    goto_pc(32'h0040_0010);
    do_accept(1, 16'h0002, 0, 0, 0, 0);
    n_checks++; if (imem_addr !== 32'h0040_001C) begin n_errors++; $display("[TB] FAIL br_fwd: got %h expected 0040001c", imem_addr); end
  endtask

  task automatic test_jump();
    goto_pc(32'h0040_0020);
    do_accept(0, 0, 1, 26'h010_0010, 0, 0);
    n_checks++; if (imem_addr !== 32'h0040_0040) begin n_errors++; $display("[TB] FAIL jmp: got %h expected 00400040", imem_addr); end
    goto_pc(32'h0040_0020);
    do_accept(0, 0, 1, 26'h010_0010, 1, 32'h0040_0107);
    n_checks++; if (imem_addr !== 32'h0040_0104) begin n_errors++; $display("[TB] FAIL jr_priority: got %h expected 00400104", imem_addr); end
    goto_pc(32'h8000_0100);
    do_accept(1, 16'h0010, 1, 26'h000_0003, 0, 0);
    n_checks++; if (imem_addr !== 32'h8000_000C) begin n_errors++; $display("[TB] FAIL jmp_over_br: got %h expected 8000000c", imem_addr); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    do_accept(0, 0, 0, 0, 0, 0);
    n_checks++; if (imem_addr !== 32'h0000_0000) begin n_errors++; $display("[TB] FAIL pc_wrap: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] w, a, tgt;
    logic [15:0] imm;
    logic [25:0] idx;
    bit seen, b, j, r;
    int unsigned rc;
    int waits, stalls;
    for (int t = 0; t < 40; t++) begin
      waits = int'($urandom_range(0, 3));
      for (int k = 0; k < waits; k++) begin
        imem_ready = 1'b0;
        @(negedge clk);
      end
      w = $urandom;
      serve_fetch(w, seen, a, rc);
      n_checks++; if (a !== model_pc) begin n_errors++; $display("[TB] FAIL rnd_addr: got %h expected %h", a, model_pc); end
      n_checks++; if (instr_out !== w) begin n_errors++; $display("[TB] FAIL rnd_instr: got %h expected %h", instr_out, w); end
      n_checks++; if (instr_pc !== model_pc) begin n_errors++; $display("[TB] FAIL rnd_pc: got %h expected %h", instr_pc, model_pc); end
      stalls = int'($urandom_range(0, 2));
      for (int k = 0; k < stalls; k++) begin
        instr_accept = 1'b0;
        junk_redirect();
        @(negedge clk);
      end
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      imm = 16'($urandom);
      idx = 26'($urandom);
      tgt = $urandom;
      do_accept(b, imm, j, idx, r, tgt);
      n_checks++; if (instr_count !== model_count) begin n_errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", instr_count, model_count); end
    end
  endtask

  task automatic test_reset_in_fetch();
    logic [31:0] a;
    bit seen;
    int unsigned rc;
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    model_pc = RESET_PC;
    model_count = 0;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL rf_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("[TB] FAIL rf_req: got %b expected 0", imem_req); end
    n_checks++; if (instr_count !== 32'd0) begin n_errors++; $display("[TB] FAIL rf_count: got %0d expected 0", instr_count); end
    n_checks++; if (instr_out !== 32'd0) begin n_errors++; $display("[TB] FAIL rf_instr: got %h expected 0", instr_out); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("[TB] FAIL rf_refetch_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("[TB] FAIL rf_refetch_addr: got %h expected %h", imem_addr, RESET_PC); end
    serve_fetch($urandom, seen, a, rc);
    do_accept(0, 0, 0, 0, 0, 0);
    n_checks++; if (instr_count !== 32'd1) begin n_errors++; $display("[TB] FAIL rf_count_after: got %0d expected 1", instr_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_random();
    test_reset_in_fetch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
